pc_fetch_unit_206: RTL and testbench

Instruction-fetch stage that owns the program counter for the processor. It holds the current word address, requests the instruction at that address from instruction memory over a request/acknowledge handshake, and presents the fetched word to decode. When the core retires the instruction, it loads the next word address produced by the next-PC logic. It sits directly downstream of the next-PC block: its PC output is that block's PC input, and that block's next-address output comes back as this block's load value.

---
 rtl/pc_fetch_unit_206.sv | 87 ++++++++
 tb/tb_pc_fetch_unit_206.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit_206.sv
// Instruction-fetch stage: owns the program counter, fetches one word per
// request/acknowledge handshake and holds it for decode until Advance.
module pc_fetch_unit_206 #(
    parameter logic [29:0] RESET_ADDR = 30'h0000_0C00,
    parameter int          MAX_WAIT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] Next_I_Addr,
    input  logic        Advance,
    output logic [31:2] PC_Addr,
    output logic [31:0] Instr,
    output logic        Instr_Valid,
    output logic        IM_Req,
    output logic [31:2] IM_Addr,
    input  logic        IM_Ack,
    input  logic [31:0] IM_RData,
    output logic        Fetch_Err,
    output logic [31:0] Fetch_Count
);

    localparam int                WAIT_W     = $clog2(MAX_WAIT) + 1;
    localparam bit                TIMEOUT_EN = (MAX_WAIT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            PC_Addr     <= RESET_ADDR;
            Instr       <= '0;
            Instr_Valid <= 1'b0;
            Fetch_Err   <= 1'b0;
            Fetch_Count <= '0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    // An ack on the limit cycle wins over the timeout.
                    if (IM_Ack) begin
                        Instr       <= IM_RData;
                        Instr_Valid <= 1'b1;
                        Fetch_Count <= Fetch_Count + 32'd1;
                        wait_cnt    <= '0;
                        state       <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
                            state       <= ERR;
                            Fetch_Err   <= 1'b1;
                            Instr_Valid <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (Advance) begin
                        PC_Addr     <= Next_I_Addr;
                        Instr_Valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                ERR: begin
                    Instr_Valid <= 1'b0;
                    Fetch_Err   <= 1'b1;
                end
                default: begin
                    state       <= ERR;
                    Instr_Valid <= 1'b0;
                    Fetch_Err   <= 1'b1;
                end
            endcase
        end
    end

    // Gated by rst so the request drops the moment reset is asserted.
    assign IM_Req  = (state == FETCH) && !rst;
    assign IM_Addr = PC_Addr;

endmodule

// File: tb/tb_pc_fetch_unit_206.sv
// Scoreboard bench for pc_fetch_unit_206: two instances (MAX_WAIT 16 and 4)
// share one stimulus stream; captured words are checked against a queue.
module tb_pc_fetch_unit_206;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [29:0] next_addr;
    logic        advance;
    logic        im_ack;
    logic [31:0] im_rdata;

    logic [29:0] pc_a, addr_a, pc_b, addr_b;
    logic [31:0] instr_a, cnt_a, instr_b, cnt_b;
    logic        vld_a, req_a, err_a, vld_b, req_b, err_b;

    pc_fetch_unit_206 #(.RESET_ADDR(30'h0000_0C00), .MAX_WAIT(16)) dut_a (
        .clk(clk), .rst(rst), .Next_I_Addr(next_addr), .Advance(advance),
        .PC_Addr(pc_a), .Instr(instr_a), .Instr_Valid(vld_a), .IM_Req(req_a),
        .IM_Addr(addr_a), .IM_Ack(im_ack), .IM_RData(im_rdata),
        .Fetch_Err(err_a), .Fetch_Count(cnt_a)
    );

    pc_fetch_unit_206 #(.RESET_ADDR(30'h0000_0C00), .MAX_WAIT(4)) dut_b (
        .clk(clk), .rst(rst), .Next_I_Addr(next_addr), .Advance(advance),
        .PC_Addr(pc_b), .Instr(instr_b), .Instr_Valid(vld_b), .IM_Req(req_b),
        .IM_Addr(addr_b), .IM_Ack(im_ack), .IM_RData(im_rdata),
        .Fetch_Err(err_b), .Fetch_Count(cnt_b)
    );

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [29:0] pc_exp;
    logic [31:0] cnt_exp;
    logic [31:0] instr_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch one word from the current PC after 'waits' unacknowledged cycles.
    task automatic fetch_word(input logic [31:0] data, input int waits);
        exp_t e;
        cnt_exp   = cnt_exp + 32'd1;
        e.pc      = pc_exp;
        e.instr   = data;
        e.cnt     = cnt_exp;
        sb_q.push_back(e);
        im_ack = 1'b0;
        for (int i = 0; i < waits; i++) begin
            check("wait_req", 32'(req_a), 1);
            tick();
            check("wait_vld", 32'(vld_a), 0);
            check("wait_err", 32'(err_a) + 32'(err_b), 0);
        end
        im_ack   = 1'b1;
        im_rdata = data;
        tick();
        im_ack   = 1'b0;
        im_rdata = $urandom;
        check("vld_rise_a", 32'(vld_a), 1);
        check("vld_rise_b", 32'(vld_b), 1);
        if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check("instr_a", instr_a, e.instr);
            check("pc_a", 32'(pc_a), 32'(e.pc));
            check("count_a", cnt_a, e.cnt);
            check("instr_b", instr_b, e.instr);
            check("count_b", cnt_b, e.cnt);
        end
        instr_exp = data;
    endtask

    // Retire the held word and load the next address.
    task automatic advance_to(input logic [29:0] a);
        check("hold_vld", 32'(vld_a), 1);
        check("hold_req", 32'(req_a), 0);
        advance   = 1'b1;
        next_addr = a;
        tick();
        advance   = 1'b0;
        next_addr = 30'($urandom);
        pc_exp    = a;
        check("adv_pc_a", 32'(pc_a), 32'(a));
        check("adv_pc_b", 32'(pc_b), 32'(a));
        check("adv_addr_a", 32'(addr_a), 32'(a));
        check("adv_req_a", 32'(req_a), 1);
        check("adv_vld_a", 32'(vld_a), 0);
    endtask

    initial begin
        rst       = 1'b1;
        advance   = 1'b0;
        im_ack    = 1'b0;
        im_rdata  = '0;
        next_addr = '0;
        pc_exp    = 30'h0C00;
        cnt_exp   = '0;
        instr_exp = '0;
        repeat (2) tick();

        check("rst_req", 32'(req_a), 0);
        check("rst_pc", 32'(pc_a), 32'h0C00);
        check("rst_instr", instr_a, 0);
        check("rst_vld", 32'(vld_a), 0);
        check("rst_err", 32'(err_a), 0);
        check("rst_count", cnt_a, 0);

        rst = 1'b0;
        #1;
        check("rel_req", 32'(req_a), 1);
        check("rel_addr", 32'(addr_a), 32'h0C00);
        fetch_word(32'h2408_0005, 0);

        repeat (3) begin
            tick();
            check("hold_stay_vld", 32'(vld_a), 1);
            check("hold_stay_instr", instr_a, instr_exp);
        end

        advance_to(30'h0C01);
        fetch_word(32'h8C09_0004, 3);

        // Spurious ack while holding
        im_ack   = 1'b1;
        im_rdata = 32'hDEAD_BEEF;
        tick();
        im_ack = 1'b0;
        check("spur_ack_instr", instr_a, instr_exp);
        check("spur_ack_count", cnt_a, cnt_exp);
        check("spur_ack_pc", 32'(pc_a), 32'(pc_exp));
        check("spur_ack_vld", 32'(vld_a), 1);

        // Advance while fetching is ignored
        advance_to(30'h0C05);
        advance   = 1'b1;
        next_addr = 30'h1234;
        tick();
        advance = 1'b0;
        check("spur_adv_pc_a", 32'(pc_a), 32'h0C05);
        check("spur_adv_pc_b", 32'(pc_b), 32'h0C05);
        check("spur_adv_vld", 32'(vld_a), 0);
        fetch_word(32'hAC0A_0008, 0);

        for (int i = 0; i < 4; i++) begin
            advance_to(30'($urandom));
            fetch_word($urandom, int'($urandom_range(0, 3)));
        end

        // dut_b (MAX_WAIT=4) times out; dut_a keeps waiting
        advance_to(30'h2000);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("to_pre_err_b", 32'(err_b), 0);
            check("to_pre_req_b", 32'(req_b), 1);
        end
        tick();
        check("to_err_b", 32'(err_b), 1);
        check("to_req_b", 32'(req_b), 0);
        check("to_pc_b", 32'(pc_b), 32'h2000);
        check("to_vld_b", 32'(vld_b), 0);
        check("to_err_a", 32'(err_a), 0);
        check("to_req_a", 32'(req_a), 1);

        im_ack    = 1'b1;
        im_rdata  = 32'h1111_2222;
        advance   = 1'b1;
        next_addr = 30'h3000;
        tick();
        im_ack  = 1'b0;
        advance = 1'b0;
        check("err_stick_b", 32'(err_b), 1);
        check("err_pc_b", 32'(pc_b), 32'h2000);
        check("err_count_b", cnt_b, cnt_exp);
        check("err_instr_b", instr_b, instr_exp);
        check("err_vld_b", 32'(vld_b), 0);
        check("late_vld_a", 32'(vld_a), 1);
        check("late_instr_a", instr_a, 32'h1111_2222);
        check("late_count_a", cnt_a, cnt_exp + 32'd1);
        check("late_pc_a", 32'(pc_a), 32'h2000);

        advance   = 1'b1;
        next_addr = 30'h2100;
        tick();
        advance = 1'b0;
        check("err_adv_pc_b", 32'(pc_b), 32'h2000);
        check("adv2_pc_a", 32'(pc_a), 32'h2100);

        // dut_a (MAX_WAIT=16) timeout boundary
        repeat (15) tick();
        check("to16_pre_err", 32'(err_a), 0);
        check("to16_pre_req", 32'(req_a), 1);
        tick();
        check("to16_err", 32'(err_a), 1);
        check("to16_req", 32'(req_a), 0);
        check("to16_pc", 32'(pc_a), 32'h2100);

        // Only reset clears the fault
        rst = 1'b1;
        #1;
        check("clr_err_a", 32'(err_a), 0);
        check("clr_err_b", 32'(err_b), 0);
        check("clr_pc_b", 32'(pc_b), 32'h0C00);
        check("clr_count_b", cnt_b, 0);
        tick();
        rst     = 1'b0;
        pc_exp  = 30'h0C00;
        cnt_exp = '0;
        fetch_word(32'h2408_0005, 0);

        // Reset during a fetch with the ack pending
        advance_to(30'h0C40);
        im_ack   = 1'b1;
        im_rdata = 32'h5555_AAAA;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_req", 32'(req_a), 0);
        check("midrst_pc", 32'(pc_a), 32'h0C00);
        check("midrst_vld", 32'(vld_a), 0);
        check("midrst_instr", instr_a, 0);
        check("midrst_count", cnt_a, 0);
        tick();
        im_ack = 1'b0;
        rst    = 1'b0;
        #1;
        check("post_rst_req", 32'(req_a), 1);
        check("post_rst_addr_a", 32'(addr_a), 32'h0C00);
        check("post_rst_addr_b", 32'(addr_b), 32'h0C00);
        pc_exp  = 30'h0C00;
        cnt_exp = '0;
        fetch_word(32'h3C01_1000, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
